conv3_cu: RTL and testbench
===========================

// Module: conv3_cu
// PURPOSE
//  Control unit for the C5 convolution stage, directly downstream of the pool-2 stage.
//  - Accepts a finished IFM set from pool-2 through the start/end handshake.
//  - Sequences IFM and weight read addresses, MAC clear/enable strobes and OFM write addresses.
//  - Hands the completed OFM set to the next stage.
//  - Control only: the datapath (IFM banks, weight ROM, MAC units) sits outside this block.
// PARAMETERS
//  IFM_SIZE          5    IFM side length (pixels)
//  IFM_DEPTH         16   IFM channels, one memory bank each
//  KERNAL_SIZE       5    square kernel side
//  NUMBER_OF_FILTERS 120  total output maps
//  NUMBER_OF_UNITS   3    parallel MAC units (filters per pass); must divide NUMBER_OF_FILTERS
//  PIPE_LATENCY      3    read-issue-to-accumulated-result latency; must be >= 2
//  derived: OFM_SIZE = IFM_SIZE-KERNAL_SIZE+1
//           GROUPS   = NUMBER_OF_FILTERS/NUMBER_OF_UNITS
//           TERMS    = IFM_DEPTH*KERNAL_SIZE^2
//           ADDRESS_SIZE_IFM = clog2(IFM_SIZE^2)
//           ADDRESS_SIZE_WGT = clog2(GROUPS*TERMS)
//           ADDRESS_SIZE_OFM = clog2(GROUPS*OFM_SIZE^2)
// PORTS
//  clk                 in  1    single clock; all logic on posedge
//  reset               in  1    synchronous, active-low
//  start_from_previous in  1    1-cycle pulse from pool-2: IFM set is complete
//  end_from_next       in  1    high = next stage can accept an OFM set
//  end_to_previous     out 1    high = IFM buffer free; pool-2 may hand over
//  ifm_enable_read     out 1    IFM bank read strobe
//  ifm_sel_current     out clog2(IFM_DEPTH)   IFM bank (channel) select
//  ifm_address_read    out ADDRESS_SIZE_IFM   IFM pixel address
//  weight_enable_read  out 1    weight ROM read strobe (same cycle as IFM read)
//  weight_address_read out ADDRESS_SIZE_WGT   weight address
//  mac_clear           out 1    MACs load (not add) this product
//  mac_enable          out 1    MACs consume the current product
//  ofm_enable_write    out 1    write all NUMBER_OF_UNITS accumulators
//  ofm_address_write   out ADDRESS_SIZE_OFM   OFM write address
//  start_to_next       out 1    1-cycle pulse: OFM set complete and handed over
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): FSM goes to IDLE and all counters/pipes clear.
//   After reset all outputs are 0, except end_to_previous=1.
//  FSM states and transitions:
//   IDLE: end_to_previous=1; on start_from_previous -> CONV on the next cycle.
//   CONV: end_to_previous=0; issues one read per cycle (both enables=1).
//         After the last read of the last group -> DRAIN.
//   DRAIN: no reads; waits PIPE_LATENCY cycles for the final OFM write -> FINISH.
//   FINISH: holds while end_from_next==0.
//           When end_from_next==1: start_to_next=1 for that cycle -> IDLE.
//  Loop nest, outer to inner: group g, oy, ox, channel d, kernel row r, kernel col c.
//   Each counter wraps to 0 at its max and carries to the next outer counter.
//  Addresses per CONV cycle:
//   ifm_address_read    = (oy+r)*IFM_SIZE + (ox+c)
//   ifm_sel_current     = d
//   weight_address_read = g*TERMS + d*KERNAL_SIZE^2 + r*KERNAL_SIZE + c
//  MAC strobes:
//   mac_enable = read enable delayed 1 cycle.
//   mac_clear  = (d,r,c)==0 flag delayed 1 cycle; it coincides with mac_enable.
//  OFM write:
//   ofm_enable_write pulses PIPE_LATENCY cycles after the read with d,r,c all at max.
//   ofm_address_write starts at 0 and increments after each write.
//   Address order is g*OFM_SIZE^2 + oy*OFM_SIZE + ox; it wraps to 0 after the final write.
//  Throughput: GROUPS*OFM_SIZE^2*TERMS CONV cycles per frame, with no bubbles.
//  end_to_previous returns to 1 only in IDLE, i.e. after the OFM set has been handed over.
//  start_from_previous outside IDLE is ignored (protocol violation; bench asserts it never occurs).
//  end_from_next already high on entering FINISH: start_to_next fires on the first FINISH cycle.
//  Reset asserted mid-frame: abandons the frame immediately.
//   No further write or MAC strobe is issued, including writes already in the delay pipe.
// STRUCTURE
//  Shared package lenet_pkg holds:
//   - the FSM state encoding (IDLE/CONV/DRAIN/FINISH)
//   - the derived-size localparams and a clog2-based width helper
//  One natural sub-module, window_counter:
//   - the cascaded g/oy/ox/d/r/c counters with wrap/carry outputs and a last-term flag.
//  The strobe delay line (PIPE_LATENCY deep) and the handshake FSM stay in conv3_cu.
// TESTING
//  Small-parameter bench config:
//   IFM_SIZE=3, K=2, DEPTH=2, FILTERS=2, UNITS=1, PIPE_LATENCY=3
//   -> OFM_SIZE=2, TERMS=8, GROUPS=2
//  1 Reset with outputs idle -> end_to_previous=1; all other outputs 0.
//  2 start pulse -> first 8 reads:
//     ifm addr 0,1,3,4 with sel 0, then 0,1,3,4 with sel 1; weight addr 0..7.
//     mac_clear only on the 1st mac_enable.
//  3 Full frame -> 64 reads total; group 1 weight addrs 8..15.
//     8 ofm writes at addr 0..7, each 3 cycles after its 8th term.
//     Pixel (1,1) reads ifm addr 4,5,7,8.
//  4 end_from_next=0 at frame end -> FSM stays in FINISH with no start_to_next.
//     Raise end_from_next after 10 cycles -> exactly one start_to_next pulse.
//     end_to_previous=1 the next cycle.
//  5 start_from_previous pulsed during CONV -> ignored; address sequence unchanged.
//  6 reset low mid-CONV (cycle 20) -> next cycle all strobes 0, end_to_previous=1.
//     A new start replays scenario 2 exactly.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet conv stages: FSM encoding, default sizes
// and the address-width helper.
package lenet_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int IFM_SIZE_D          = 5;
  localparam int IFM_DEPTH_D         = 16;
  localparam int KERNAL_SIZE_D       = 5;
  localparam int NUMBER_OF_FILTERS_D = 120;
  localparam int NUMBER_OF_UNITS_D   = 3;
  localparam int PIPE_LATENCY_D      = 3;

  // Width able to index n items; never below one bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv3_cu_if.sv
// Handshake and memory-control bundle between conv3_cu and its surroundings.
interface conv3_cu_if #(
  parameter int SEL_W  = 4,
  parameter int IFM_AW = 5,
  parameter int WGT_AW = 14,
  parameter int OFM_AW = 6
);
  logic              start_from_previous;
  logic              end_from_next;
  logic              end_to_previous;
  logic              ifm_enable_read;
  logic [SEL_W-1:0]  ifm_sel_current;
  logic [IFM_AW-1:0] ifm_address_read;
  logic              weight_enable_read;
  logic [WGT_AW-1:0] weight_address_read;
  logic              mac_clear;
  logic              mac_enable;
  logic              ofm_enable_write;
  logic [OFM_AW-1:0] ofm_address_write;
  logic              start_to_next;

  modport master (
    input  start_from_previous, end_from_next,
    output end_to_previous, ifm_enable_read, ifm_sel_current, ifm_address_read,
           weight_enable_read, weight_address_read, mac_clear, mac_enable,
           ofm_enable_write, ofm_address_write, start_to_next
  );

  modport slave (
    output start_from_previous, end_from_next,
    input  end_to_previous, ifm_enable_read, ifm_sel_current, ifm_address_read,
           weight_enable_read, weight_address_read, mac_clear, mac_enable,
           ofm_enable_write, ofm_address_write, start_to_next
  );
endinterface

// File: rtl/conv3_cu_window_counter.sv
// Cascaded g/oy/ox/d/r/c loop counters for the convolution window walk.
module window_counter
  import lenet_pkg::*;
#(
  parameter int GROUPS      = 40,
  parameter int OFM_SIZE    = 1,
  parameter int IFM_DEPTH   = 16,
  parameter int KERNAL_SIZE = 5,
  parameter int GW = width_of(GROUPS),
  parameter int OW = width_of(OFM_SIZE),
  parameter int DW = width_of(IFM_DEPTH),
  parameter int KW = width_of(KERNAL_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_step,
  output logic [GW-1:0] o_g,
  output logic [OW-1:0] o_oy,
  output logic [OW-1:0] o_ox,
  output logic [DW-1:0] o_d,
  output logic [KW-1:0] o_r,
  output logic [KW-1:0] o_c,
  output logic          o_first_term,
  output logic          o_last_term,
  output logic          o_last_all
);
  localparam logic [GW-1:0] G_MAX = GW'(GROUPS - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OFM_SIZE - 1);
  localparam logic [DW-1:0] D_MAX = DW'(IFM_DEPTH - 1);
  localparam logic [KW-1:0] K_MAX = KW'(KERNAL_SIZE - 1);

  logic [GW-1:0] r_g;
  logic [OW-1:0] r_oy, r_ox;
  logic [DW-1:0] r_d;
  logic [KW-1:0] r_r, r_c;
  logic w_c_wrap, w_r_wrap, w_d_wrap, w_ox_wrap, w_oy_wrap, w_g_wrap;

  // Each wrap flag means this counter and every inner one sit at max.
  assign w_c_wrap  = (r_c == K_MAX);
  assign w_r_wrap  = w_c_wrap  & (r_r  == K_MAX);
  assign w_d_wrap  = w_r_wrap  & (r_d  == D_MAX);
  assign w_ox_wrap = w_d_wrap  & (r_ox == O_MAX);
  assign w_oy_wrap = w_ox_wrap & (r_oy == O_MAX);
  assign w_g_wrap  = w_oy_wrap & (r_g  == G_MAX);

  // Counter cascade: advance on each issued read, carry on wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_g  <= GW'(0);
      r_oy <= OW'(0);
      r_ox <= OW'(0);
      r_d  <= DW'(0);
      r_r  <= KW'(0);
      r_c  <= KW'(0);
    end else if (i_step) begin
      r_c <= w_c_wrap ? KW'(0) : r_c + KW'(1);
      if (w_c_wrap)  r_r  <= (r_r  == K_MAX) ? KW'(0) : r_r  + KW'(1);
      if (w_r_wrap)  r_d  <= (r_d  == D_MAX) ? DW'(0) : r_d  + DW'(1);
      if (w_d_wrap)  r_ox <= (r_ox == O_MAX) ? OW'(0) : r_ox + OW'(1);
      if (w_ox_wrap) r_oy <= (r_oy == O_MAX) ? OW'(0) : r_oy + OW'(1);
      if (w_oy_wrap) r_g  <= (r_g  == G_MAX) ? GW'(0) : r_g  + GW'(1);
    end
  end

  assign o_g          = r_g;
  assign o_oy         = r_oy;
  assign o_ox         = r_ox;
  assign o_d          = r_d;
  assign o_r          = r_r;
  assign o_c          = r_c;
  assign o_first_term = (r_d == DW'(0)) && (r_r == KW'(0)) && (r_c == KW'(0));
  assign o_last_term  = w_d_wrap;
  assign o_last_all   = w_g_wrap;
endmodule

// File: rtl/conv3_cu.sv
// C5 convolution control unit: pool-2/next-stage handshake, read address
// sequencing, MAC strobes and OFM write addressing.
module conv3_cu
  import lenet_pkg::*;
#(
  parameter int IFM_SIZE          = IFM_SIZE_D,
  parameter int IFM_DEPTH         = IFM_DEPTH_D,
  parameter int KERNAL_SIZE       = KERNAL_SIZE_D,
  parameter int NUMBER_OF_FILTERS = NUMBER_OF_FILTERS_D,
  parameter int NUMBER_OF_UNITS   = NUMBER_OF_UNITS_D,
  parameter int PIPE_LATENCY      = PIPE_LATENCY_D
) (
  input logic        clk,
  input logic        reset,
  conv3_cu_if.master bus
);
  localparam int OFM_SIZE = IFM_SIZE - KERNAL_SIZE + 1;
  localparam int GROUPS   = NUMBER_OF_FILTERS / NUMBER_OF_UNITS;
  localparam int KK       = KERNAL_SIZE * KERNAL_SIZE;
  localparam int TERMS    = IFM_DEPTH * KK;
  localparam int IFM_AW   = width_of(IFM_SIZE * IFM_SIZE);
  localparam int WGT_AW   = width_of(GROUPS * TERMS);
  localparam int OFM_AW   = width_of(GROUPS * OFM_SIZE * OFM_SIZE);
  localparam int GW = width_of(GROUPS);
  localparam int OW = width_of(OFM_SIZE);
  localparam int DW = width_of(IFM_DEPTH);
  localparam int KW = width_of(KERNAL_SIZE);
  localparam int CW = width_of(PIPE_LATENCY);
  localparam logic [CW-1:0]     DRAIN_LAST = CW'(PIPE_LATENCY - 1);
  localparam logic [OFM_AW-1:0] OFM_LAST   = OFM_AW'(GROUPS * OFM_SIZE * OFM_SIZE - 1);

  logic [1:0]              r_state;
  logic [CW-1:0]           r_drain_cnt;
  logic [PIPE_LATENCY-1:0] r_wr_pipe;
  logic                    r_mac_en, r_mac_clr;
  logic [OFM_AW-1:0]       r_ofm_addr;

  logic          w_rd_en, w_first, w_last, w_last_all;
  logic [GW-1:0] w_g;
  logic [OW-1:0] w_oy, w_ox;
  logic [DW-1:0] w_d;
  logic [KW-1:0] w_r, w_c;

  assign w_rd_en = (r_state == ST_CONV);

  window_counter #(
    .GROUPS(GROUPS), .OFM_SIZE(OFM_SIZE), .IFM_DEPTH(IFM_DEPTH), .KERNAL_SIZE(KERNAL_SIZE)
  ) u_window (
    .clk(clk), .reset(reset), .i_step(w_rd_en),
    .o_g(w_g), .o_oy(w_oy), .o_ox(w_ox), .o_d(w_d), .o_r(w_r), .o_c(w_c),
    .o_first_term(w_first), .o_last_term(w_last), .o_last_all(w_last_all)
  );

  // Frame handshake FSM; DRAIN covers the tail of the write delay line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= CW'(0);
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.start_from_previous) r_state <= ST_CONV;
        ST_CONV: begin
          r_drain_cnt <= CW'(0);
          if (w_last_all) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) r_state <= ST_FINISH;
          else                           r_drain_cnt <= r_drain_cnt + CW'(1);
        end
        ST_FINISH: if (bus.end_from_next) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // MAC strobes trail the read by one cycle; write strobe by PIPE_LATENCY.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mac_en   <= 1'b0;
      r_mac_clr  <= 1'b0;
      r_wr_pipe  <= {PIPE_LATENCY{1'b0}};
      r_ofm_addr <= OFM_AW'(0);
    end else begin
      r_mac_en  <= w_rd_en;
      r_mac_clr <= w_rd_en & w_first;
      r_wr_pipe <= {r_wr_pipe[PIPE_LATENCY-2:0], w_rd_en & w_last};
      if (r_wr_pipe[PIPE_LATENCY-1])
        r_ofm_addr <= (r_ofm_addr == OFM_LAST) ? OFM_AW'(0) : r_ofm_addr + OFM_AW'(1);
    end
  end

  assign bus.end_to_previous     = (r_state == ST_IDLE);
  assign bus.ifm_enable_read     = w_rd_en;
  assign bus.weight_enable_read  = w_rd_en;
  assign bus.ifm_sel_current     = w_d;
  assign bus.ifm_address_read    = IFM_AW'((32'(w_oy) + 32'(w_r)) * IFM_SIZE + 32'(w_ox) + 32'(w_c));
  assign bus.weight_address_read = WGT_AW'(32'(w_g) * TERMS + 32'(w_d) * KK
                                           + 32'(w_r) * KERNAL_SIZE + 32'(w_c));
  assign bus.mac_enable          = r_mac_en;
  assign bus.mac_clear           = r_mac_clr;
  assign bus.ofm_enable_write    = r_wr_pipe[PIPE_LATENCY-1];
  assign bus.ofm_address_write   = r_ofm_addr;
  assign bus.start_to_next       = (r_state == ST_FINISH) & bus.end_from_next;
endmodule

// File: tb/tb_conv3_cu.sv
// Scoreboard bench for conv3_cu on a reduced configuration (3x3 IFM, 2x2 kernel).
module tb_conv3_cu;
  import lenet_pkg::*;

  localparam int IFM = 3, K = 2, DEP = 2, FIL = 2, UNI = 1, PL = 3;
  localparam int OFM = IFM - K + 1;
  localparam int GRP = FIL / UNI;
  localparam int TERMS = DEP * K * K;
  localparam int SEL_W = width_of(DEP);
  localparam int IFM_AW = width_of(IFM * IFM);
  localparam int WGT_AW = width_of(GRP * TERMS);
  localparam int OFM_AW = width_of(GRP * OFM * OFM);

  typedef struct { int cyc; int ifm; int sel; int wgt; } rd_t;
  typedef struct { int cyc; int clr; } mac_t;
  typedef struct { int cyc; int addr; } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   s;
  rd_t  rd_q[$];
  mac_t mac_q[$];
  wr_t  wr_q[$];

  conv3_cu_if #(.SEL_W(SEL_W), .IFM_AW(IFM_AW), .WGT_AW(WGT_AW), .OFM_AW(OFM_AW)) bus ();

  conv3_cu #(
    .IFM_SIZE(IFM), .IFM_DEPTH(DEP), .KERNAL_SIZE(K), .NUMBER_OF_FILTERS(FIL),
    .NUMBER_OF_UNITS(UNI), .PIPE_LATENCY(PL)
  ) u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({bus.end_to_previous, bus.ifm_enable_read, bus.weight_enable_read,
                bus.mac_clear, bus.mac_enable, bus.ofm_enable_write, bus.start_to_next,
                8'(bus.ifm_sel_current), 8'(bus.ifm_address_read),
                8'(bus.weight_address_read), 8'(bus.ofm_address_write)});
  endfunction

  localparam logic [63:0] IDLE_EXP = 64'h40_0000_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  // Expected transactions for a frame whose start pulse is sampled in cycle st.
  task automatic push_frame(input int st);
    int k = 0;
    int w = 0;
    for (int g = 0; g < GRP; g++)
      for (int oy = 0; oy < OFM; oy++)
        for (int ox = 0; ox < OFM; ox++)
          for (int d = 0; d < DEP; d++)
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++) begin
                rd_q.push_back('{st + 1 + k, (oy + r) * IFM + ox + c, d,
                                 g * TERMS + d * K * K + r * K + c});
                mac_q.push_back('{st + 2 + k, (d == 0 && r == 0 && c == 0) ? 1 : 0});
                if (d == DEP - 1 && r == K - 1 && c == K - 1) begin
                  wr_q.push_back('{st + 1 + k + PL, w});
                  w++;
                end
                k++;
              end
  endtask

  task automatic chk_empty();
    chk("rd_left", 64'(rd_q.size()), 64'd0);
    chk("mac_left", 64'(mac_q.size()), 64'd0);
    chk("wr_left", 64'(wr_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    rd_t rd;
    mac_t m;
    wr_t w;
    if (mon_en) begin
      if (bus.ifm_enable_read) begin
        if (rd_q.size() == 0) chk("rd_extra", 64'd1, 64'd0);
        else begin
          rd = rd_q.pop_front();
          chk("rd", {32'(cyc), 8'(bus.ifm_address_read), 8'(bus.ifm_sel_current),
                     8'(bus.weight_address_read), 8'(bus.weight_enable_read)},
                    {32'(rd.cyc), 8'(rd.ifm), 8'(rd.sel), 8'(rd.wgt), 8'd1});
        end
      end else begin
        if (bus.weight_enable_read) chk("wen_stray", 64'd1, 64'd0);
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) chk("rd_miss", 64'd0, 64'd1);
      end
      if (bus.mac_enable) begin
        if (mac_q.size() == 0) chk("mac_extra", 64'd1, 64'd0);
        else begin
          m = mac_q.pop_front();
          chk("mac", {32'(cyc), 32'(bus.mac_clear)}, {32'(m.cyc), 32'(m.clr)});
        end
      end else begin
        if (bus.mac_clear) chk("clr_stray", 64'd1, 64'd0);
        if (mac_q.size() > 0 && mac_q[0].cyc == cyc) chk("mac_miss", 64'd0, 64'd1);
      end
      if (bus.ofm_enable_write) begin
        if (wr_q.size() == 0) chk("wr_extra", 64'd1, 64'd0);
        else begin
          w = wr_q.pop_front();
          chk("wr", {32'(cyc), 32'(bus.ofm_address_write)}, {32'(w.cyc), 32'(w.addr)});
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc == cyc) chk("wr_miss", 64'd0, 64'd1);
    end
  end

  initial begin
    reset = 1'b0;
    bus.start_from_previous = 1'b0;
    bus.end_from_next = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_idle", outs_vec(), IDLE_EXP);
    step();
    reset = 1'b1;
    mon_en = 1'b1;
    step();

    // Full frame, stray start mid-CONV, next stage busy at frame end.
    s = cyc;
    push_frame(s);
    bus.start_from_previous = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
    go_to(s + 10);
    bus.start_from_previous = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
    go_to(s + 67);
    @(negedge clk);
    chk("etp_busy", 64'(bus.end_to_previous), 64'd0);
    for (int i = 0; i < 10; i++) begin
      go_to(s + 68 + i);
      @(negedge clk);
      chk("hold", {62'd0, bus.start_to_next, bus.end_to_previous}, 64'd0);
    end
    go_to(s + 78);
    bus.end_from_next = 1'b1;
    @(negedge clk);
    chk("handoff", 64'(bus.start_to_next), 64'd1);
    step();
    bus.end_from_next = 1'b0;
    @(negedge clk);
    chk("etp_back", {62'd0, bus.start_to_next, bus.end_to_previous}, 64'd1);
    chk_empty();

    // Reset during CONV abandons the frame.
    step();
    step();
    s = cyc;
    push_frame(s);
    bus.start_from_previous = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
    go_to(s + 20);
    reset = 1'b0;
    step();
    rd_q.delete();
    mac_q.delete();
    wr_q.delete();
    @(negedge clk);
    chk("rst_mid", outs_vec(), IDLE_EXP);
    step();
    reset = 1'b1;
    step();
    step();

    // Replay with the next stage already ready when FINISH is reached.
    bus.end_from_next = 1'b1;
    s = cyc;
    push_frame(s);
    bus.start_from_previous = 1'b1;
    step();
    bus.start_from_previous = 1'b0;
    go_to(s + 67);
    @(negedge clk);
    chk("pre_finish", 64'(bus.start_to_next), 64'd0);
    step();
    @(negedge clk);
    chk("finish_first", 64'(bus.start_to_next), 64'd1);
    step();
    bus.end_from_next = 1'b0;
    @(negedge clk);
    chk("idle_again", {62'd0, bus.start_to_next, bus.end_to_previous}, 64'd1);
    chk_empty();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
